// File: rtl/mfm_sync_framer.sv
// -----------------------------------------------------------------------------
// mfm_sync_framer
//   Consumes the recovered MFM cell stream from the DPLL/decoder and frames it.
//   It hunts for the missing-clock address-mark word, counts the run of
//   consecutive marks, and then assembles each following 16 cells into one
//   data byte. Encoding violations (two adjacent 1 cells, or four consecutive
//   0 cells) while framed drop the framer back to hunting and raise sync_error.
//
// Ports
//   clk_50      in   system clock
//   reset       in   synchronous, active-high reset
//   enable      in   0 = held in hunt, no pulses
//   cell_valid  in   one-cycle strobe per recovered cell
//   cell_bit    in   cell value, first cell of a word first
//   byte_data   out  framed data byte (data cells only), MSB first
//   byte_valid  out  one-cycle pulse, byte_data is valid
//   mark_found  out  one-cycle pulse per accepted mark word
//   in_frame    out  1 while in SYNC or DATA
//   sync_error  out  one-cycle pulse on lost framing
//   byte_count  out  data bytes emitted in the current frame
// -----------------------------------------------------------------------------
module mfm_sync_framer #(
  parameter logic [15:0] SYNC_PATTERN = 16'h4489,
  parameter int          SYNC_MARKS   = 3,
  parameter int          FRAME_BYTES  = 7,
  parameter int          BC_W         = 10
) (
  input  logic            clk_50,
  input  logic            reset,
  input  logic            enable,
  input  logic            cell_valid,
  input  logic            cell_bit,
  output logic [7:0]      byte_data,
  output logic            byte_valid,
  output logic            mark_found,
  output logic            in_frame,
  output logic            sync_error,
  output logic [BC_W-1:0] byte_count
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0]      SYNC_MARKS_W  = 8'(SYNC_MARKS);
  localparam logic [BC_W-1:0] FRAME_BYTES_W = BC_W'(FRAME_BYTES);
  localparam logic [BC_W-1:0] BC_ONE        = BC_W'(1);

  state_t          state_r, state_s;
  logic [15:0]     sr_r, sr_s;
  logic [3:0]      cell_cnt_r, cell_cnt_s;
  logic [2:0]      zero_run_r, zero_run_s;
  logic [7:0]      mark_cnt_r, mark_cnt_s;
  logic [7:0]      byte_data_s;
  logic            byte_valid_s;
  logic            mark_found_s;
  logic            sync_error_s;
  logic [BC_W-1:0] byte_count_s;
  logic            is_mark_s;
  logic            word_end_s;
  logic            violation_s;

  // Data cells sit at the even positions of the word; odd positions are clocks.
  function automatic logic [7:0] extract_data(input logic [15:0] w);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      d[i] = w[2*i];
    end
    return d;
  endfunction

  // Next-state, counters and output pulses, all decided on the updated word.
  always_comb begin
    state_s      = state_r;
    cell_cnt_s   = cell_cnt_r;
    zero_run_s   = zero_run_r;
    mark_cnt_s   = mark_cnt_r;
    byte_data_s  = byte_data;
    byte_valid_s = 1'b0;
    mark_found_s = 1'b0;
    sync_error_s = 1'b0;
    byte_count_s = byte_count;

    if (cell_valid) begin
      sr_s = {sr_r[14:0], cell_bit};
    end else begin
      sr_s = sr_r;
    end

    is_mark_s  = (sr_s == SYNC_PATTERN);
    word_end_s = (cell_cnt_r == 4'd15);
    // A fourth consecutive zero or a 1 following a 1 is illegal MFM.
    violation_s = cell_valid && ((sr_s[1:0] == 2'b11) ||
                                 (!cell_bit && (zero_run_r == 3'd3)));

    if (!enable) begin
      state_s = HUNT;
    end else if (cell_valid) begin
      case (state_r)
        HUNT: begin
          if (is_mark_s) begin
            mark_found_s = 1'b1;
            mark_cnt_s   = 8'd1;
            cell_cnt_s   = 4'd0;
            zero_run_s   = 3'd0;
            byte_count_s = '0;
            state_s      = SYNC;
          end else begin
            state_s = HUNT;
          end
        end
        SYNC, DATA: begin
          if (violation_s) begin
            // Violation beats a coinciding word boundary: no byte, no mark.
            sync_error_s = 1'b1;
            state_s      = HUNT;
          end else begin
            zero_run_s = cell_bit ? 3'd0 : (zero_run_r + 3'd1);
            cell_cnt_s = cell_cnt_r + 4'd1;  // wraps 15 -> 0 at each word end
            if (word_end_s) begin
              if (state_r == SYNC) begin
                if (is_mark_s) begin
                  mark_found_s = 1'b1;
                  mark_cnt_s   = (mark_cnt_r == 8'hFF) ? mark_cnt_r : (mark_cnt_r + 8'd1);
                end else if (mark_cnt_r >= SYNC_MARKS_W) begin
                  byte_valid_s = 1'b1;
                  byte_data_s  = extract_data(sr_s);
                  byte_count_s = BC_ONE;
                  state_s      = (FRAME_BYTES_W == BC_ONE) ? HUNT : DATA;
                end else begin
                  sync_error_s = 1'b1;
                  state_s      = HUNT;
                end
              end else begin
                byte_valid_s = 1'b1;
                byte_data_s  = extract_data(sr_s);
                byte_count_s = byte_count + BC_ONE;
                if (byte_count_s == FRAME_BYTES_W) begin
                  state_s = HUNT;
                end else begin
                  state_s = DATA;
                end
              end
            end else begin
              state_s = state_r;
            end
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_r    <= HUNT;
      sr_r       <= 16'h0000;
      cell_cnt_r <= 4'd0;
      zero_run_r <= 3'd0;
      mark_cnt_r <= 8'd0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      mark_found <= 1'b0;
      sync_error <= 1'b0;
      in_frame   <= 1'b0;
      byte_count <= '0;
    end else begin
      state_r    <= state_s;
      sr_r       <= sr_s;
      cell_cnt_r <= cell_cnt_s;
      zero_run_r <= zero_run_s;
      mark_cnt_r <= mark_cnt_s;
      byte_data  <= byte_data_s;
      byte_valid <= byte_valid_s;
      mark_found <= mark_found_s;
      sync_error <= sync_error_s;
      in_frame   <= (state_s != HUNT);
      byte_count <= byte_count_s;
    end
  end

endmodule
